// File: rtl/sci_uart.sv
// Memory-mapped 8N1 serial port with 16x oversampled receiver, RX FIFO and double-buffered TX.
// Define SCI_LOOPBACK_EN to add the LOOPS control bit (STAT[4]) that routes TX back into RX.
module sci_uart #(
  parameter int unsigned RXDEPTH   = 4,
  parameter int unsigned SBR_RESET = 27
) (
  input  logic       i_clk50,
  input  logic       i_resetn,
  input  logic [7:0] i_din,
  output logic [7:0] o_dout,
  input  logic       i_sel,
  input  logic [1:0] i_regaddr,
  input  logic       i_rd,
  input  logic       i_wr,
  input  logic       i_rxd,
  output logic       o_txd
);
  localparam int unsigned AW = $clog2(RXDEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;

  // Bus strobes are multi-cycle levels; act once per access.
  logic       r_wr_q, r_rd_q;
  logic [1:0] r_rd_addr;
  logic       w_wr_lvl, w_rd_lvl, w_wr_edge, w_rd_fall;
  assign w_wr_lvl  = i_sel & i_wr;
  assign w_rd_lvl  = i_sel & i_rd;
  assign w_wr_edge = w_wr_lvl & ~r_wr_q;
  assign w_rd_fall = r_rd_q & ~w_rd_lvl;

  always_ff @(posedge i_clk50 or negedge i_resetn) begin
    if (!i_resetn) begin
      r_wr_q    <= 1'b0;
      r_rd_q    <= 1'b0;
      r_rd_addr <= 2'd0;
    end else begin
      r_wr_q <= w_wr_lvl;
      r_rd_q <= w_rd_lvl;
      if (w_rd_lvl) r_rd_addr <= i_regaddr;
    end
  end

  logic [12:0] r_sbr, r_bcnt;
  logic        w_tick;
  assign w_tick = (r_sbr != 13'd0) && (r_bcnt <= 13'd1);

  always_ff @(posedge i_clk50 or negedge i_resetn) begin
    if (!i_resetn) begin
      r_sbr  <= 13'(SBR_RESET);
      r_bcnt <= 13'(SBR_RESET);
    end else begin
      if (w_tick) r_bcnt <= r_sbr;
      else if (r_sbr != 13'd0) r_bcnt <= r_bcnt - 13'd1;
      if (w_wr_edge && i_regaddr == 2'd2) r_sbr[12:8] <= i_din[4:0];
      if (w_wr_edge && i_regaddr == 2'd3) begin
        r_sbr[7:0] <= i_din;
        r_bcnt     <= {r_sbr[12:8], i_din};
      end
    end
  end

  logic w_loops;
`ifdef SCI_LOOPBACK_EN
  logic r_loops;
  always_ff @(posedge i_clk50 or negedge i_resetn) begin
    if (!i_resetn) r_loops <= 1'b0;
    else if (w_wr_edge && i_regaddr == 2'd0) r_loops <= i_din[4];
  end
  assign w_loops = r_loops;
`else
  assign w_loops = 1'b0;
`endif

  logic      r_txo;
  logic      r_rx_s1, r_rx_s2;
  logic      w_rx_src;
  assign w_rx_src = w_loops ? r_txo : i_rxd;
  assign o_txd    = r_txo | w_loops;

  rx_state_e r_rx_state;
  logic [3:0] r_rx_cnt;
  logic [2:0] r_rx_bit;
  logic [7:0] r_rx_sh;
  logic       r_rx_push, r_rx_fe;

  always_ff @(posedge i_clk50 or negedge i_resetn) begin
    if (!i_resetn) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_state <= R_IDLE;
      r_rx_cnt   <= 4'd0;
      r_rx_bit   <= 3'd0;
      r_rx_sh    <= 8'd0;
      r_rx_push  <= 1'b0;
      r_rx_fe    <= 1'b0;
    end else begin
      r_rx_s1   <= w_rx_src;
      r_rx_s2   <= r_rx_s1;
      r_rx_push <= 1'b0;
      if (w_tick) begin
        case (r_rx_state)
          R_IDLE: if (!r_rx_s2) begin
            r_rx_state <= R_START;
            r_rx_cnt   <= 4'd1;
          end
          // 8th tick is mid start bit: a high line here was only a glitch.
          R_START: if (r_rx_cnt == 4'd7) begin
            r_rx_cnt   <= 4'd0;
            r_rx_bit   <= 3'd0;
            r_rx_state <= r_rx_s2 ? R_IDLE : R_DATA;
          end else r_rx_cnt <= r_rx_cnt + 4'd1;
          R_DATA: if (r_rx_cnt == 4'd15) begin
            r_rx_cnt <= 4'd0;
            r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= R_STOP;
            else r_rx_bit <= r_rx_bit + 3'd1;
          end else r_rx_cnt <= r_rx_cnt + 4'd1;
          R_STOP: if (r_rx_cnt == 4'd15) begin
            r_rx_cnt   <= 4'd0;
            r_rx_push  <= 1'b1;
            r_rx_fe    <= ~r_rx_s2;
            r_rx_state <= R_IDLE;
          end else r_rx_cnt <= r_rx_cnt + 4'd1;
          default: r_rx_state <= R_IDLE;
        endcase
      end
    end
  end

  logic [7:0]    r_mem [RXDEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_or, r_fe, r_stat_rd;
  logic          w_full, w_push_ok, w_pop, w_rdrf;
  assign w_full    = (r_count == CW'(RXDEPTH));
  assign w_push_ok = r_rx_push & ~w_full;
  assign w_rdrf    = (r_count != '0);
  assign w_pop     = w_rd_fall && (r_rd_addr == 2'd1) && w_rdrf;

  always_ff @(posedge i_clk50) begin
    if (w_push_ok) r_mem[r_wptr] <= r_rx_sh;
  end

  always_ff @(posedge i_clk50 or negedge i_resetn) begin
    if (!i_resetn) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_or      <= 1'b0;
      r_fe      <= 1'b0;
      r_stat_rd <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop);
      if (w_rd_fall && r_rd_addr == 2'd0) r_stat_rd <= 1'b1;
      else if (w_rd_fall && r_rd_addr == 2'd1) begin
        if (r_stat_rd) begin
          r_or <= 1'b0;
          r_fe <= 1'b0;
        end
        r_stat_rd <= 1'b0;
      end
      if (r_rx_push && w_full) r_or <= 1'b1;
      if (r_rx_push && r_rx_fe) r_fe <= 1'b1;
    end
  end

  tx_state_e r_tx_state;
  logic [3:0] r_tx_cnt;
  logic [2:0] r_tx_bit;
  logic [7:0] r_tx_sh, r_thr;
  logic       r_thr_full, r_tc;

  always_ff @(posedge i_clk50 or negedge i_resetn) begin
    if (!i_resetn) begin
      r_tx_state <= T_IDLE;
      r_tx_cnt   <= 4'd0;
      r_tx_bit   <= 3'd0;
      r_tx_sh    <= 8'd0;
      r_txo      <= 1'b1;
      r_thr      <= 8'd0;
      r_thr_full <= 1'b0;
      r_tc       <= 1'b1;
    end else begin
      case (r_tx_state)
        T_IDLE: if (r_thr_full && r_sbr != 13'd0) begin
          r_tx_state <= T_START;
          r_tx_sh    <= r_thr;
          r_thr_full <= 1'b0;
          r_txo      <= 1'b0;
          r_tx_cnt   <= 4'd0;
        end
        T_START: if (w_tick) begin
          if (r_tx_cnt == 4'd15) begin
            r_tx_state <= T_DATA;
            r_txo      <= r_tx_sh[0];
            r_tx_sh    <= {1'b0, r_tx_sh[7:1]};
            r_tx_bit   <= 3'd0;
            r_tx_cnt   <= 4'd0;
          end else r_tx_cnt <= r_tx_cnt + 4'd1;
        end
        T_DATA: if (w_tick) begin
          if (r_tx_cnt == 4'd15) begin
            r_tx_cnt <= 4'd0;
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= T_STOP;
              r_txo      <= 1'b1;
            end else begin
              r_txo    <= r_tx_sh[0];
              r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
              r_tx_bit <= r_tx_bit + 3'd1;
            end
          end else r_tx_cnt <= r_tx_cnt + 4'd1;
        end
        T_STOP: if (w_tick) begin
          if (r_tx_cnt == 4'd15) begin
            r_tx_cnt <= 4'd0;
            if (r_thr_full) begin
              r_tx_state <= T_START;
              r_tx_sh    <= r_thr;
              r_thr_full <= 1'b0;
              r_txo      <= 1'b0;
            end else begin
              r_tx_state <= T_IDLE;
              r_tc       <= 1'b1;
            end
          end else r_tx_cnt <= r_tx_cnt + 4'd1;
        end
        default: r_tx_state <= T_IDLE;
      endcase
      // Placed last so a CPU write wins over a same-cycle shifter load.
      if (w_wr_edge && i_regaddr == 2'd1) begin
        r_thr      <= i_din;
        r_thr_full <= 1'b1;
        r_tc       <= 1'b0;
      end
    end
  end

  always_comb begin
    o_dout = 8'd0;
    if (i_sel) begin
      case (i_regaddr)
        2'd0:    o_dout = {~r_thr_full, r_tc, w_rdrf, w_loops, r_or, 1'b0, r_fe, 1'b0};
        2'd1:    o_dout = w_rdrf ? r_mem[r_rptr] : 8'd0;
        2'd2:    o_dout = {3'b000, r_sbr[12:8]};
        default: o_dout = r_sbr[7:0];
      endcase
    end
  end
endmodule

// File: tb/tb_sci_uart.sv
// Directed bench for sci_uart: register access, TX framing, RX FIFO/flags, baud freeze, reset.
module tb_sci_uart;
  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] din;
  logic [7:0] dout;
  logic       sel;
  logic [1:0] regaddr;
  logic       rd;
  logic       wr;
  logic       rxd;
  logic       txd;

  int n_checks = 0;
  int n_fail   = 0;

  sci_uart #(.RXDEPTH(4), .SBR_RESET(27)) dut (
    .i_clk50   (clk),
    .i_resetn  (resetn),
    .i_din     (din),
    .o_dout    (dout),
    .i_sel     (sel),
    .i_regaddr (regaddr),
    .i_rd      (rd),
    .i_wr      (wr),
    .i_rxd     (rxd),
    .o_txd     (txd)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    sel = 1'b1; regaddr = a; din = d; wr = 1'b1;
    cyc(hold);
    wr = 1'b0; sel = 1'b0;
    cyc(4);
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    sel = 1'b1; regaddr = a; rd = 1'b1;
    cyc(4);
    d = dout;
    rd = 1'b0; sel = 1'b0;
    cyc(4);
  endtask

  // One 8N1 frame at 32 clk50 per bit; a low stop bit is shortened so the
  // line is idle again before the receiver's next start-bit qualification.
  task automatic send_rx(input logic [7:0] b, input bit stop_ok);
    rxd = 1'b0;
    cyc(32);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      cyc(32);
    end
    if (stop_ok) begin
      rxd = 1'b1;
      cyc(32);
    end else begin
      rxd = 1'b0;
      cyc(24);
      rxd = 1'b1;
      cyc(8);
    end
    cyc(32);
  endtask

  logic [7:0] rv;
  logic [9:0] frame;
  int         k;
  int         lows;

  initial begin
    resetn = 1'b0; din = 8'd0; sel = 1'b0; regaddr = 2'd0; rd = 1'b0; wr = 1'b0; rxd = 1'b1;
    cyc(5);
    check("reset_txd", 16'(txd), 16'h1);
    check("reset_dout", 16'(dout), 16'h00);
    resetn = 1'b1;
    cyc(3);

    bus_rd(2'd2, rv); check("bdh_reset", 16'(rv), 16'h00);
    bus_rd(2'd3, rv); check("bdl_reset", 16'(rv), 16'h1B);
    bus_rd(2'd0, rv); check("stat_reset", 16'(rv), 16'hC0);

    bus_wr(2'd3, 8'h02, 4);
    bus_rd(2'd3, rv); check("bdl_written", 16'(rv), 16'h02);

    // Long write strobe must still produce exactly one frame.
    frame = '0;
    lows  = 0;
    fork
      begin
        @(negedge clk);
        sel = 1'b1; regaddr = 2'd1; din = 8'hA5; wr = 1'b1;
        cyc(500);
        wr = 1'b0; sel = 1'b0;
      end
      begin
        k = 0;
        while (txd !== 1'b0 && k < 100) begin
          @(negedge clk);
          k++;
        end
        check("tx_start_seen", 16'(k < 100), 16'h1);
        cyc(16);
        for (int i = 0; i < 10; i++) begin
          frame[i] = txd;
          cyc(32);
        end
        for (int i = 0; i < 300; i++) begin
          if (txd !== 1'b1) lows++;
          @(negedge clk);
        end
      end
    join
    check("tx_frame_a5", 16'(frame), 16'({1'b1, 8'hA5, 1'b0}));
    check("tx_single_frame", 16'(lows), 16'd0);
    bus_rd(2'd0, rv); check("stat_after_tx", 16'(rv), 16'hC0);

    bus_wr(2'd1, 8'h11, 2);
    bus_rd(2'd0, rv); check("stat_tdre_tx_busy", 16'(rv), 16'h80);
    cyc(400);
    bus_rd(2'd0, rv); check("stat_tx_done", 16'(rv), 16'hC0);

    send_rx(8'h3C, 1'b1);
    send_rx(8'h7E, 1'b1);
    bus_rd(2'd0, rv); check("stat_rx2", 16'(rv), 16'hE0);
    bus_rd(2'd1, rv); check("rx_byte0", 16'(rv), 16'h3C);
    bus_rd(2'd1, rv); check("rx_byte1", 16'(rv), 16'h7E);
    bus_rd(2'd0, rv); check("stat_rx_empty", 16'(rv), 16'hC0);
    bus_rd(2'd1, rv); check("data_empty", 16'(rv), 16'h00);

    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
    bus_rd(2'd0, rv); check("stat_overrun", 16'(rv), 16'hE8);
    bus_rd(2'd1, rv); check("ovr_byte1", 16'(rv), 16'h01);
    bus_rd(2'd0, rv); check("stat_or_cleared", 16'(rv), 16'hE0);
    bus_rd(2'd1, rv); check("ovr_byte2", 16'(rv), 16'h02);
    bus_rd(2'd1, rv); check("ovr_byte3", 16'(rv), 16'h03);
    bus_rd(2'd1, rv); check("ovr_byte4", 16'(rv), 16'h04);
    bus_rd(2'd0, rv); check("stat_ovr_drained", 16'(rv), 16'hC0);

    send_rx(8'h55, 1'b0);
    bus_rd(2'd0, rv); check("stat_framing", 16'(rv), 16'hE2);
    bus_rd(2'd1, rv); check("fe_byte", 16'(rv), 16'h55);
    bus_rd(2'd0, rv); check("stat_fe_cleared", 16'(rv), 16'hC0);

    @(negedge clk);
    rxd = 1'b0;
    cyc(8);
    rxd = 1'b1;
    cyc(400);
    bus_rd(2'd0, rv); check("stat_glitch", 16'(rv), 16'hC0);

    // SBR=0 freezes the transmitter with the byte still held.
    bus_wr(2'd3, 8'h00, 4);
    bus_wr(2'd1, 8'h5A, 4);
    cyc(100);
    bus_rd(2'd0, rv); check("stat_sbr0_frozen", 16'(rv), 16'h00);
    check("txd_sbr0_idle", 16'(txd), 16'h1);
    bus_wr(2'd3, 8'h02, 4);
    cyc(400);
    bus_rd(2'd0, rv); check("stat_sbr_resumed", 16'(rv), 16'hC0);

`ifdef SCI_LOOPBACK_EN
    bus_wr(2'd0, 8'h10, 4);
    bus_rd(2'd0, rv); check("stat_loops_set", 16'(rv), 16'hD0);
    @(negedge clk);
    sel = 1'b1; regaddr = 2'd1; din = 8'h81; wr = 1'b1;
    lows = 0;
    for (int i = 0; i < 450; i++) begin
      if (i == 4) begin
        wr = 1'b0; sel = 1'b0;
      end
      if (txd !== 1'b1) lows++;
      @(negedge clk);
    end
    check("loop_txd_high", 16'(lows), 16'd0);
    bus_rd(2'd0, rv); check("stat_loop_rx", 16'(rv), 16'hF0);
    bus_rd(2'd1, rv); check("loop_byte", 16'(rv), 16'h81);
    bus_wr(2'd0, 8'h00, 4);
    bus_rd(2'd0, rv); check("stat_loops_clr", 16'(rv), 16'hC0);
`else
    bus_wr(2'd0, 8'hFF, 4);
    bus_rd(2'd0, rv); check("stat_write_ignored", 16'(rv), 16'hC0);
`endif

    // Reset in the middle of an all-zero frame forces txd high at once.
    bus_wr(2'd1, 8'h00, 4);
    cyc(100);
    check("txd_midframe_low", 16'(txd), 16'h0);
    resetn = 1'b0;
    #1;
    check("txd_reset_async", 16'(txd), 16'h1);
    cyc(3);
    resetn = 1'b1;
    cyc(3);
    bus_rd(2'd3, rv); check("bdl_after_reset", 16'(rv), 16'h1B);
    bus_rd(2'd0, rv); check("stat_after_reset", 16'(rv), 16'hC0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sci_uart.md
Name: sci_uart

Overview:
- Memory-mapped 8N1 serial port on the MiniS08 data bus, occupying addresses 0x004–0x007.
- Upstream of the CPU: it converts the rxd pin into bytes the CPU reads, and CPU-written bytes into a txd frame.
- The CPU runs on a slow, divided clock, so one bus access spans many clk50 cycles. This block edge-detects its strobes so each access acts exactly once.

Parameters:
RXDEPTH, 4, receive FIFO depth in bytes (power of 2, 2..16)
SBR_RESET, 27, reset baud divisor (50 MHz / (16 × 27) ≈ 115200 baud)

Ports:
clk50  input  1  system clock, 50 MHz
resetn  input  1  asynchronous active-low reset
din  input  8  data bus from the CPU (write data)
dout  output  8  read data for the selected register; 0 when not selected
sel  input  1  chip select (address in 0x004–0x007)
regaddr  input  2  register offset: 0 STAT, 1 DATA, 2 BDH, 3 BDL
rd  input  1  CPU Read strobe (level, multi-cycle)
wr  input  1  CPU Write strobe (level, multi-cycle)
rxd  input  1  serial in, asynchronous to clk50, idle high
txd  output  1  serial out, idle high

Behaviour:
- Clock and reset: one clock, clk50. Reset is asynchronous and active-low on resetn.
- Reset values:
  - txd=1; dout=0.
  - FIFO empty; TX idle.
  - SBR=SBR_RESET.
  - Flags: TDRE=1, TC=1, RDRF=0, OR=0, FE=0.
- Strobe edge detection:
  - Register sel&wr and sel&rd each clk50 cycle.
  - Write action fires on the rising edge of sel&wr, using din and regaddr in that cycle.
  - Read side effects fire on the falling edge of sel&rd, after the CPU has sampled the data.
- dout (combinational from current state):
  - STAT = {TDRE, TC, RDRF, 1'b0, OR, 1'b0, FE, 1'b0}.
  - DATA = FIFO head (0 if empty).
  - BDH = {3'b0, SBR[12:8]}.
  - BDL = SBR[7:0].
- Baud generator:
  - 13-bit down-counter produces a one-clk50 pulse tick16 every SBR cycles.
  - SBR=0: tick16 is held off; RX and TX freeze in their current state.
  - A write to BDL reloads the counter. A write to BDH only updates SBR[12:8].
- RX path:
  - rxd passes through a 2-flop synchronizer.
  - FSM R_IDLE → R_START → R_DATA → R_STOP → R_IDLE, sampling on tick16.
  - R_IDLE: a low level starts the sample count.
  - R_START: at the 8th tick16 the line is re-checked. If it is high (false start), return to R_IDLE.
  - R_DATA: sample every 16 ticks; 8 bits, LSB first.
  - R_STOP: at the mid-point, stop=0 sets FE and the byte is still pushed.
  - FIFO full on push: the byte is dropped and OR is set.
  - RDRF = FIFO not empty.
- Reads:
  - Falling edge of a DATA read with FIFO non-empty: pop one byte. Empty: no-op.
  - Falling edge of a STAT read followed by a DATA read: clears OR and FE. Clearing happens on that DATA read's falling edge.
- TX path:
  - Write to DATA loads the holding register and clears TDRE and TC. A write while TDRE=0 overwrites the holding register.
  - FSM T_IDLE → T_START → T_DATA → T_STOP. Each bit lasts 16 tick16.
  - Leaving T_IDLE (holding register non-empty): move holding register to shifter; TDRE=1.
  - End of T_STOP: if the holding register is full, go to T_START directly (back-to-back frames). Otherwise go to T_IDLE and set TC=1.
- Simultaneous events:
  - A push and a pop in the same cycle both happen; the count is unchanged.
  - A CPU write to DATA in the same cycle the shifter loads: the shifter takes the old byte and the new byte stays held.
- resetn assertion mid-frame: txd=1 immediately, FIFO is flushed, and any partial RX byte is discarded.

Optional Feature:
SCI_LOOPBACK_EN
- Defined:
  - STAT bit 4 becomes LOOPS (R/W, reset 0); writes to STAT affect only bit 4.
  - LOOPS=1: the RX synchronizer input is the TX serializer output instead of rxd, and txd is held at 1.
- Undefined:
  - STAT bit 4 reads 0 and writes to STAT are ignored.
  - rxd always feeds RX.

Test Plan:
- Reset, then read BDH/BDL/STAT → 0x00 / 0x1B / 0xC0.
- SBR=2, write DATA=0xA5 with wr held 500 clk50 cycles → exactly one frame on txd: 0, 1,0,1,0,0,1,0,1, 1, each bit 32 clk50. TDRE=1 within 2 cycles of start; TC=1 after stop.
- SBR=2, drive rxd frames 0x3C, then 0x7E → STAT=0xE0; DATA reads return 0x3C then 0x7E; RDRF=0 after.
- Send 5 bytes with RXDEPTH=4 and no reads → STAT bit 3 set; reads return the first 4 bytes. A STAT read then a DATA read clears OR.
- Receive a frame with stop bit=0 (byte 0x55) → FE=1, 0x55 in FIFO. A 4-tick low glitch on rxd → nothing received.
- With SCI_LOOPBACK_EN and LOOPS=1, write DATA=0x81 → RDRF=1, DATA reads 0x81, txd stays 1 throughout.
